// File: rtl/core_arb_pkg.sv
// Shared types and constants for the CNN core arbiter: operand/result widths,
// core mode select encoding and the arbiter state encoding.
package core_arb_pkg;

  localparam int DW_DEF = 72;  // nine 8-bit lanes
  localparam int RW_DEF = 8;

  localparam logic SEL_CONV = 1'b0;
  localparam logic SEL_FC   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_FC   = 2'd2,
    ST_FULL = 2'd3
  } arb_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/arb_tag_fifo.sv
// Source-tag FIFO: one bit per in-flight core operation, popped in issue order
// so each result can be routed back to the requester that issued it.
module arb_tag_fifo
  import core_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic dout,
  output logic empty,
  output logic full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are valid, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/core_arbiter.sv
// Time-shares the CNN compute core between the convolution and FC operand
// streams (FC priority, bounded convolution starvation) and routes results back
// by source tag. Define CORE_ARB_PERF_CNT_EN to build the grant/preemption counters.
module core_arbiter
  import core_arb_pkg::*;
#(
  parameter int DW         = DW_DEF,
  parameter int RW         = RW_DEF,
  parameter int MAX_OUT    = 4,
  parameter int STARVE_MAX = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          conv_valid,
  input  logic [DW-1:0] conv_data,
  input  logic [DW-1:0] conv_filter,
  output logic          conv_ready,
  input  logic          fc_valid,
  input  logic [DW-1:0] fc_data,
  input  logic [DW-1:0] fc_weight,
  output logic          fc_ready,
  output logic          core_valid,
  output logic [DW-1:0] core_data,
  output logic [DW-1:0] core_weight,
  output logic          core_sel,
  input  logic          core_res_valid,
  input  logic [RW-1:0] core_res,
  output logic          conv_out_valid,
  output logic [RW-1:0] conv_out,
  output logic          fc_out_valid,
  output logic [RW-1:0] fc_out,
  output logic          busy,
  output logic          tag_err,
  output logic [15:0]   perf_conv,
  output logic [15:0]   perf_fc,
  output logic [15:0]   perf_preempt
);

  localparam int CW = $clog2(MAX_OUT) + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_FULL   = CW'(MAX_OUT);
  localparam logic [SW-1:0] STARVE_CAP = SW'(STARVE_MAX);

  arb_state_e    state;
  arb_state_e    state_nxt;
  logic [CW-1:0] inflight;
  logic [CW-1:0] inflight_nxt;
  logic [SW-1:0] starve_cnt;
  logic          can_issue;
  logic          starved;
  logic          conv_grant;
  logic          fc_grant;
  logic          grant;
  logic          grant_sel;
  logic          tag_pop;
  logic          tag_head;
  logic          tag_empty;
  logic          tag_full;

  // NOTE: every always_comb output gets a value on every path (defaults first)
  // so no latch is inferred.
  always_comb begin
    // Full-check uses the registered count, so a same-cycle return cannot open a slot.
    can_issue  = rst_n && (inflight != CNT_FULL) && !tag_full;
    starved    = conv_valid && (starve_cnt == STARVE_CAP);
    fc_grant   = can_issue && fc_valid && !starved;
    conv_grant = can_issue && conv_valid && (!fc_valid || starved);
  end

  assign conv_ready = conv_grant;
  assign fc_ready   = fc_grant;
  assign grant      = conv_grant || fc_grant;
  assign grant_sel  = fc_grant ? SEL_FC : SEL_CONV;
  assign tag_pop    = core_res_valid && !tag_empty;
  assign busy       = (inflight != '0) || (state != ST_IDLE);

  always_comb begin
    inflight_nxt = inflight;
    case ({grant, tag_pop})
      2'b10:   inflight_nxt = inflight + CW'(1);
      2'b01:   inflight_nxt = inflight - CW'(1);
      default: inflight_nxt = inflight;
    endcase
  end

  always_comb begin
    state_nxt = ST_IDLE;
    if (inflight_nxt == CNT_FULL) state_nxt = ST_FULL;
    else if (conv_grant)          state_nxt = ST_CONV;
    else if (fc_grant)            state_nxt = ST_FC;
  end

  arb_tag_fifo #(.DEPTH(MAX_OUT)) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (grant),
    .din   (grant_sel),
    .pop   (tag_pop),
    .dout  (tag_head),
    .empty (tag_empty),
    .full  (tag_full)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      inflight       <= '0;
      starve_cnt     <= '0;
      core_valid     <= 1'b0;
      core_data      <= '0;
      core_weight    <= '0;
      core_sel       <= SEL_CONV;
      conv_out_valid <= 1'b0;
      conv_out       <= '0;
      fc_out_valid   <= 1'b0;
      fc_out         <= '0;
      tag_err        <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= inflight_nxt;

      if (conv_grant || !conv_valid)
        starve_cnt <= '0;
      else if (fc_grant && (starve_cnt != STARVE_CAP))
        starve_cnt <= starve_cnt + SW'(1);

      core_valid <= grant;
      if (grant) begin
        core_sel    <= grant_sel;
        core_data   <= fc_grant ? fc_data : conv_data;
        core_weight <= fc_grant ? fc_weight : conv_filter;
      end

      conv_out_valid <= 1'b0;
      fc_out_valid   <= 1'b0;
      if (core_res_valid) begin
        if (tag_empty) begin
          tag_err <= 1'b1;
        end else if (tag_head == SEL_FC) begin
          fc_out       <= core_res;
          fc_out_valid <= 1'b1;
        end else begin
          conv_out       <= core_res;
          conv_out_valid <= 1'b1;
        end
      end
    end
  end

`ifdef CORE_ARB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_conv    <= '0;
      perf_fc      <= '0;
      perf_preempt <= '0;
    end else begin
      if (conv_grant) perf_conv <= sat_inc16(perf_conv);
      if (fc_grant)   perf_fc   <= sat_inc16(perf_fc);
      if (fc_grant && (state == ST_CONV)) perf_preempt <= sat_inc16(perf_preempt);
    end
  end
`else
  assign perf_conv    = '0;
  assign perf_fc      = '0;
  assign perf_preempt = '0;
`endif

endmodule

// File: tb/tb_core_arbiter.sv
// Self-checking bench for core_arbiter: stub core with fixed latency, operand
// and result scoreboards, grant-rule model and reset/tag-error scenarios.
module tb_core_arbiter;
  import core_arb_pkg::*;

  localparam int DW  = 72;
  localparam int RW  = 8;
  localparam int LAT = 2;

  typedef struct {
    logic          sel;
    logic [DW-1:0] d;
    logic [DW-1:0] w;
  } iss_t;

  typedef struct {
    logic          sel;
    logic [RW-1:0] v;
  } exp_t;

  typedef struct {
    int            t;
    logic [RW-1:0] v;
  } ret_t;

  logic          clk;
  logic          rst_n;
  logic          conv_valid;
  logic [DW-1:0] conv_data;
  logic [DW-1:0] conv_filter;
  logic          conv_ready;
  logic          fc_valid;
  logic [DW-1:0] fc_data;
  logic [DW-1:0] fc_weight;
  logic          fc_ready;
  logic          core_valid;
  logic [DW-1:0] core_data;
  logic [DW-1:0] core_weight;
  logic          core_sel;
  logic          core_res_valid;
  logic [RW-1:0] core_res;
  logic          conv_out_valid;
  logic [RW-1:0] conv_out;
  logic          fc_out_valid;
  logic [RW-1:0] fc_out;
  logic          busy;
  logic          tag_err;
  logic [15:0]   perf_conv;
  logic [15:0]   perf_fc;
  logic [15:0]   perf_preempt;

  core_arbiter #(.DW(DW), .RW(RW), .MAX_OUT(4), .STARVE_MAX(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .conv_valid     (conv_valid),
    .conv_data      (conv_data),
    .conv_filter    (conv_filter),
    .conv_ready     (conv_ready),
    .fc_valid       (fc_valid),
    .fc_data        (fc_data),
    .fc_weight      (fc_weight),
    .fc_ready       (fc_ready),
    .core_valid     (core_valid),
    .core_data      (core_data),
    .core_weight    (core_weight),
    .core_sel       (core_sel),
    .core_res_valid (core_res_valid),
    .core_res       (core_res),
    .conv_out_valid (conv_out_valid),
    .conv_out       (conv_out),
    .fc_out_valid   (fc_out_valid),
    .fc_out         (fc_out),
    .busy           (busy),
    .tag_err        (tag_err),
    .perf_conv      (perf_conv),
    .perf_fc        (perf_fc),
    .perf_preempt   (perf_preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  iss_t          iss_q[$];
  exp_t          exp_q[$];
  ret_t          ret_q[$];
  logic [RW-1:0] core_vals_q[$];
  logic [RW-1:0] user_vals[$];

  int cyc       = 0;
  int n_iss_cv  = 0;
  int n_iss_fc  = 0;
  bit stall     = 1'b0;
  int release_n = 0;
  bit conv_taken = 1'b0;
  bit fc_taken   = 1'b0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_dw();
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < DW / 8; i++) r[i*8 +: 8] = 8'($urandom);
    return r;
  endfunction

  // Stub core: accepts issues, returns each result LAT negedges later, in order.
  initial begin
    iss_t          ie;
    logic [RW-1:0] v;
    core_res_valid = 1'b0;
    core_res       = '0;
    forever begin
      @(negedge clk);
      cyc++;
      core_res_valid = 1'b0;
      if (ret_q.size() > 0 && ret_q[0].t <= cyc && (!stall || release_n > 0)) begin
        core_res_valid = 1'b1;
        core_res       = ret_q[0].v;
        void'(ret_q.pop_front());
        if (stall) release_n--;
      end
      if (core_valid === 1'b1) begin
        if (core_sel === SEL_FC) n_iss_fc++;
        else n_iss_cv++;
        if (iss_q.size() == 0) begin
          check("unexpected_issue", DW'(1), DW'(0));
        end else begin
          ie = iss_q.pop_front();
          check("issue_sel", DW'(core_sel), DW'(ie.sel));
          check("issue_data", core_data, ie.d);
          check("issue_weight", core_weight, ie.w);
        end
        v = (core_vals_q.size() > 0) ? core_vals_q.pop_front() : 8'h00;
        ret_q.push_back('{cyc + LAT, v});
      end
    end
  end

  // Result monitor: every routed strobe is popped against the expected queue.
  initial begin
    exp_t          e;
    logic          sel;
    logic [RW-1:0] v;
    forever begin
      @(negedge clk);
      if (conv_out_valid === 1'b1 && fc_out_valid === 1'b1) begin
        check("both_out_strobes", DW'(1), DW'(0));
      end else if (conv_out_valid === 1'b1 || fc_out_valid === 1'b1) begin
        sel = fc_out_valid;
        v   = sel ? fc_out : conv_out;
        if (exp_q.size() == 0) begin
          check("unexpected_result", DW'(v), DW'(0));
        end else begin
          e = exp_q.pop_front();
          check("result_sel", DW'(sel), DW'(e.sel));
          check("result_val", DW'(v), DW'(e.v));
        end
      end
    end
  end

  task automatic push_op(input logic sel, input logic [DW-1:0] d, input logic [DW-1:0] w);
    logic [RW-1:0] v;
    v = (user_vals.size() > 0) ? user_vals.pop_front() : 8'($urandom);
    core_vals_q.push_back(v);
    exp_q.push_back('{sel, v});
    iss_q.push_back('{sel, d, w});
  endtask

  // One cycle of stimulus: drive valids, check readys against the model grant.
  task automatic cycle(input logic cv, input logic fv, input logic exp_c, input logic exp_f);
    @(negedge clk);
    if (conv_taken) begin
      conv_data   = rand_dw();
      conv_filter = rand_dw();
      conv_taken  = 1'b0;
    end
    if (fc_taken) begin
      fc_data   = rand_dw();
      fc_weight = rand_dw();
      fc_taken  = 1'b0;
    end
    conv_valid = cv;
    fc_valid   = fv;
    #1;
    check("conv_ready", DW'(conv_ready), DW'(exp_c));
    check("fc_ready", DW'(fc_ready), DW'(exp_f));
    if (exp_c) begin
      push_op(SEL_CONV, conv_data, conv_filter);
      conv_taken = 1'b1;
    end
    if (exp_f) begin
      push_op(SEL_FC, fc_data, fc_weight);
      fc_taken = 1'b1;
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || ret_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || ret_q.size() != 0)
      check("drain_timeout", DW'(exp_q.size() + ret_q.size()), DW'(0));
    repeat (2) @(negedge clk);
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_core_valid"}, DW'(core_valid), DW'(0));
    check({pfx, "_core_sel"}, DW'(core_sel), DW'(0));
    check({pfx, "_core_data"}, core_data, DW'(0));
    check({pfx, "_core_weight"}, core_weight, DW'(0));
    check({pfx, "_conv_out_valid"}, DW'(conv_out_valid), DW'(0));
    check({pfx, "_conv_out"}, DW'(conv_out), DW'(0));
    check({pfx, "_fc_out_valid"}, DW'(fc_out_valid), DW'(0));
    check({pfx, "_fc_out"}, DW'(fc_out), DW'(0));
    check({pfx, "_busy"}, DW'(busy), DW'(0));
    check({pfx, "_tag_err"}, DW'(tag_err), DW'(0));
    check({pfx, "_conv_ready"}, DW'(conv_ready), DW'(0));
    check({pfx, "_fc_ready"}, DW'(fc_ready), DW'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    conv_valid = 1'b0;
    fc_valid   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  s;
    bit  exp_c;
    bit  prev_c;
    int  m_conv;
    int  m_fc;
    int  m_pre;
    int  base_cv;
    int  base_fc;
    logic res_prev;

    rst_n       = 1'b0;
    conv_valid  = 1'b0;
    fc_valid    = 1'b0;
    conv_data   = rand_dw();
    conv_filter = rand_dw();
    fc_data     = rand_dw();
    fc_weight   = rand_dw();
    repeat (2) @(negedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;

    // Convolution only, three back-to-back pairs.
    base_cv = n_iss_cv;
    base_fc = n_iss_fc;
    user_vals.push_back(8'h11);
    user_vals.push_back(8'h22);
    user_vals.push_back(8'h33);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    drain(40);
    check("t1_conv_issues", DW'(n_iss_cv - base_cv), DW'(3));
    check("t1_fc_issues", DW'(n_iss_fc - base_fc), DW'(0));
    check("t1_idle_busy", DW'(busy), DW'(0));

    // Both valids held: FC priority with starvation relief every 16 FC grants.
    do_reset();
    s = 0; prev_c = 1'b0; m_conv = 0; m_fc = 0; m_pre = 0;
    for (int i = 0; i < 40; i++) begin
      exp_c = (s == 16);
      cycle(1'b1, 1'b1, exp_c, !exp_c);
      if (exp_c) begin
        m_conv++;
        s = 0;
      end else begin
        m_fc++;
        if (prev_c) m_pre++;
        if (s < 16) s++;
      end
      prev_c = exp_c;
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    drain(60);
`ifdef CORE_ARB_PERF_CNT_EN
    check("t2_perf_conv", DW'(perf_conv), DW'(m_conv));
    check("t2_perf_fc", DW'(perf_fc), DW'(m_fc));
    check("t2_perf_preempt", DW'(perf_preempt), DW'(m_pre));
`else
    check("t2_perf_conv_tied", DW'(perf_conv), DW'(0));
    check("t2_perf_fc_tied", DW'(perf_fc), DW'(0));
    check("t2_perf_preempt_tied", DW'(perf_preempt), DW'(0));
`endif

    // Stalled core: four grants fill the window, one return frees one slot.
    stall = 1'b1;
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("t3_busy_full", DW'(busy), DW'(1));
    release_n = 1;
    res_prev  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, res_prev, 1'b0);
      res_prev = core_res_valid;
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("t3_busy_stalled", DW'(busy), DW'(1));
    stall = 1'b0;
    drain(60);
    check("t3_busy_drained", DW'(busy), DW'(0));

    // Interleaved FC, CONV, FC with fixed results.
    user_vals.push_back(8'hA0);
    user_vals.push_back(8'hB0);
    user_vals.push_back(8'hC0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    drain(40);

    // Stray result with nothing in flight sets a sticky tag error.
    do_reset();
    check("t5_tag_err_clear", DW'(tag_err), DW'(0));
    @(negedge clk);
    #1;
    ret_q.push_back('{cyc + 1, 8'h5A});
    repeat (4) @(negedge clk);
    check("t5_tag_err_set", DW'(tag_err), DW'(1));
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    drain(40);
    check("t5_tag_err_sticky", DW'(tag_err), DW'(1));

    // Reset with two operations in flight; their late results hit an empty FIFO.
    do_reset();
    stall = 1'b1;
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("t6_busy_inflight", DW'(busy), DW'(1));
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check_zero("t6_reset");
    exp_q.delete();
    rst_n = 1'b1;
    stall = 1'b0;
    drain(40);
    check("t6_late_tag_err", DW'(tag_err), DW'(1));
    check("t6_busy_after", DW'(busy), DW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
